main_fsm_decoder: RTL and testbench

Multicycle successor to the single-cycle main decoder. This FSM sequences each instruction through fetch, decode, execute, memory and writeback over several clocks, and talks to a shared instruction/data memory through a req/ready handshake. Multiply runs as an iterative operation over a parametrised number of cycles. The block sits in the controller beside the ALU decoder and condition logic, which gate `pc_w`, `reg_w3`, `reg_w1` and `mem_w` with the condition result.

---
 rtl/main_fsm_decoder.sv | 156 +++++++++++++++
 tb/tb_main_fsm_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm_decoder.sv
// Multicycle main decoder FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional iterative multiply states are built only when MAIN_FSM_MULT_EN is defined.
module main_fsm_decoder #(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] instr74,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_w,
   output logic       adr_src,
   output logic       ir_w,
   output logic       pc_w,
   output logic       branch,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic       alu_op,
   output logic       reg_w3,
   output logic       reg_w1,
   output logic       post_idx,
   output logic       mul_busy,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXR, S_EXI, S_ALUWB, S_MADR,
      S_MRD, S_MWB, S_MWR, S_BR, S_BXEX, S_MUL, S_MULWB
   } state_t;

   state_t state;

   logic is_bx, is_mul_enc, mul_ok, is_dp, is_mem, is_br, dec_illegal;
   logic is_load, is_link, post, base_wb;

   // Instruction class, from IR fields that are stable from DECODE onward.
   assign is_bx      = (op == 2'b00) && (funct == 6'b010010) && (instr74 == 4'b0001);
   assign is_mul_enc = (op == 2'b00) && (funct[5:4] == 2'b00) && (instr74 == 4'b1001);
   assign is_dp      = (op == 2'b00) && !is_bx && !is_mul_enc;
   assign is_mem     = (op == 2'b01);
   assign is_br      = (op == 2'b10) && funct[5];
   assign is_load    = funct[0];
   assign is_link    = funct[4];
   assign post       = ~funct[4];
   assign base_wb    = ~funct[4] | funct[1];
`ifdef MAIN_FSM_MULT_EN
   assign mul_ok     = is_mul_enc;
`else
   assign mul_ok     = 1'b0;
`endif
   assign dec_illegal = !(is_bx | mul_ok | is_dp | is_mem | is_br);
   assign state_dbg   = state;

`ifdef MAIN_FSM_MULT_EN
   logic [CNT_W-1:0] cnt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_RST;
`ifdef MAIN_FSM_MULT_EN
         cnt   <= '0;
`endif
      end else begin
         case (state)
            S_RST:    state <= S_FETCH;
            S_FETCH:  if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               if (is_bx)        state <= S_BXEX;
`ifdef MAIN_FSM_MULT_EN
               else if (mul_ok) begin
                  state <= S_MUL;
                  cnt   <= CNT_W'(MUL_CYCLES - 1);
               end
`endif
               else if (is_dp)   state <= funct[5] ? S_EXI : S_EXR;
               else if (is_mem)  state <= S_MADR;
               else if (is_br)   state <= S_BR;
               else              state <= S_FETCH;
            end
            S_EXR, S_EXI: state <= S_ALUWB;
            S_MADR:   state <= is_load ? S_MRD : S_MWR;
            S_MRD:    if (mem_ready) state <= S_MWB;
            S_MWR:    if (mem_ready) state <= S_FETCH;
`ifdef MAIN_FSM_MULT_EN
            S_MUL: begin
               if (cnt == '0) state <= S_MULWB;
               else           cnt   <= cnt - 1'b1;
            end
            S_MULWB:  state <= S_FETCH;
`endif
            S_ALUWB, S_MWB, S_BR, S_BXEX: state <= S_FETCH;
            default:  state <= S_RST;
         endcase
      end
   end

   always_comb begin
      mem_req = 1'b0; mem_w = 1'b0; adr_src = 1'b0; ir_w = 1'b0; pc_w = 1'b0;
      branch = 1'b0; alu_src_a = 2'b00; alu_src_b = 2'b00; result_src = 2'b00;
      imm_src = 2'b00; reg_src = 2'b00; alu_op = 1'b0; reg_w3 = 1'b0;
      reg_w1 = 1'b0; post_idx = 1'b0; mul_busy = 1'b0; illegal = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1; alu_src_a = 2'b01; alu_src_b = 2'b10; result_src = 2'b10;
            ir_w = mem_ready; pc_w = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01; alu_src_b = 2'b10; illegal = dec_illegal;
            if (is_mem) begin
               imm_src = 2'b01; reg_src = is_load ? 2'b00 : 2'b10;
            end else if (is_br) begin
               imm_src = 2'b10; reg_src = is_link ? 2'b11 : 2'b01;
            end
         end
         S_EXR: alu_op = 1'b1;
         S_EXI: begin
            alu_src_b = 2'b01; alu_op = 1'b1;
         end
         S_ALUWB: reg_w3 = 1'b1;
         S_MADR: begin
            alu_src_b = funct[5] ? 2'b00 : 2'b01; imm_src = 2'b01; post_idx = post;
         end
         S_MRD: begin
            mem_req = 1'b1; adr_src = 1'b1; post_idx = post;
         end
         S_MWB: begin
            result_src = 2'b01; reg_w3 = 1'b1; reg_w1 = base_wb;
         end
         S_MWR: begin
            mem_req = 1'b1; mem_w = 1'b1; adr_src = 1'b1; post_idx = post;
            reg_w1 = base_wb & mem_ready;
         end
         S_BR: begin
            branch = 1'b1; imm_src = 2'b10; alu_src_a = 2'b01; alu_src_b = 2'b01;
            reg_w3 = is_link; reg_src = is_link ? 2'b11 : 2'b00;
         end
         S_BXEX: branch = 1'b1;
`ifdef MAIN_FSM_MULT_EN
         S_MUL: mul_busy = 1'b1;
         S_MULWB: begin
            reg_w1 = 1'b1; reg_w3 = funct[3];
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_main_fsm_decoder.sv
// Bench for main_fsm_decoder: random instruction stream and random memory waits
// checked cycle by cycle against an expected output trace built per instruction.
module tb_main_fsm_decoder;

   localparam int MC = 4;

   typedef struct packed {
      logic       mem_req, mem_w, adr_src, ir_w, pc_w, branch;
      logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
      logic       alu_op, reg_w3, reg_w1, post_idx, mul_busy, illegal;
   } outs_t;

   localparam int C_DP_R = 0, C_DP_I = 1, C_MEM = 2, C_BR = 3, C_BX = 4, C_MUL = 5, C_ILL = 6;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] instr74;
   logic       mem_ready;
   logic       mem_req, mem_w, adr_src, ir_w, pc_w, branch;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
   logic       alu_op, reg_w3, reg_w1, post_idx, mul_busy, illegal;
   logic [3:0] state_dbg;
   outs_t      got;

   int n_checks = 0;
   int n_errors = 0;

   logic [21:0] exp_q[$];
   logic        ready_q[$];
   string       tag_q[$];

   main_fsm_decoder #(.MUL_CYCLES(MC), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .instr74(instr74),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_w(mem_w), .adr_src(adr_src),
      .ir_w(ir_w), .pc_w(pc_w), .branch(branch), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
      .reg_src(reg_src), .alu_op(alu_op), .reg_w3(reg_w3), .reg_w1(reg_w1),
      .post_idx(post_idx), .mul_busy(mul_busy), .illegal(illegal), .state_dbg(state_dbg)
   );

   assign got = {mem_req, mem_w, adr_src, ir_w, pc_w, branch, alu_src_a, alu_src_b,
                 result_src, imm_src, reg_src, alu_op, reg_w3, reg_w1, post_idx,
                 mul_busy, illegal};

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [21:0] act, input logic [21:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %06h expected %06h", tag, act, exp);
      end
   endtask

   function automatic int classify(input logic [1:0] o, input logic [5:0] f, input logic [3:0] i);
      if (o == 2'b11) return C_ILL;
      if (o == 2'b10) return f[5] ? C_BR : C_ILL;
      if (o == 2'b01) return C_MEM;
      if (f == 6'b010010 && i == 4'b0001) return C_BX;
      if (f[5:4] == 2'b00 && i == 4'b1001) begin
`ifdef MAIN_FSM_MULT_EN
         return C_MUL;
`else
         return C_ILL;
`endif
      end
      return f[5] ? C_DP_I : C_DP_R;
   endfunction

   task automatic push(input logic r, input outs_t o, input string t);
      ready_q.push_back(r);
      exp_q.push_back(o);
      tag_q.push_back(t);
   endtask

   // Reference: expected per-cycle outputs for one instruction, fw fetch waits, mw memory waits.
   task automatic build(input logic [1:0] o, input logic [5:0] f, input logic [3:0] i,
                        input int fw, input int mw);
      outs_t e;
      int    c;
      logic  post, wb, link, rdy;
      c    = classify(o, f, i);
      post = !f[4];
      wb   = post || f[1];
      link = f[4];
      for (int k = 0; k <= fw; k++) begin
         rdy = (k == fw);
         e = '0; e.mem_req = 1; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.result_src = 2'b10;
         e.ir_w = rdy; e.pc_w = rdy;
         push(rdy, e, "FETCH");
      end
      e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
      if (c == C_MEM) begin e.imm_src = 2'b01; e.reg_src = f[0] ? 2'b00 : 2'b10; end
      if (c == C_BR)  begin e.imm_src = 2'b10; e.reg_src = link ? 2'b11 : 2'b01; end
      e.illegal = (c == C_ILL);
      push(1'($urandom_range(0, 1)), e, "DECODE");
      if (c == C_DP_R || c == C_DP_I) begin
         e = '0; e.alu_op = 1; e.alu_src_b = (c == C_DP_I) ? 2'b01 : 2'b00;
         push(1'($urandom_range(0, 1)), e, "EXEC");
         e = '0; e.reg_w3 = 1;
         push(1'($urandom_range(0, 1)), e, "ALUWB");
      end else if (c == C_MEM) begin
         e = '0; e.alu_src_b = f[5] ? 2'b00 : 2'b01; e.imm_src = 2'b01; e.post_idx = post;
         push(1'($urandom_range(0, 1)), e, "MADR");
         for (int k = 0; k <= mw; k++) begin
            rdy = (k == mw);
            e = '0; e.mem_req = 1; e.adr_src = 1; e.post_idx = post;
            if (f[0]) push(rdy, e, "MRD");
            else begin
               e.mem_w = 1; e.reg_w1 = wb && rdy;
               push(rdy, e, "MWR");
            end
         end
         if (f[0]) begin
            e = '0; e.result_src = 2'b01; e.reg_w3 = 1; e.reg_w1 = wb;
            push(1'($urandom_range(0, 1)), e, "MWB");
         end
      end else if (c == C_BR) begin
         e = '0; e.branch = 1; e.imm_src = 2'b10; e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
         e.reg_w3 = link; e.reg_src = link ? 2'b11 : 2'b00;
         push(1'($urandom_range(0, 1)), e, "BR");
      end else if (c == C_BX) begin
         e = '0; e.branch = 1;
         push(1'($urandom_range(0, 1)), e, "BXEX");
      end else if (c == C_MUL) begin
         for (int k = 0; k < MC; k++) begin
            e = '0; e.mul_busy = 1;
            push(1'($urandom_range(0, 1)), e, "MUL");
         end
         e = '0; e.reg_w1 = 1; e.reg_w3 = f[3];
         push(1'($urandom_range(0, 1)), e, "MULWB");
      end
   endtask

   // driver: entered and left at posedge+1
   task automatic play(input int max_entries);
      int n = 0;
      while (exp_q.size() > 0 && n < max_entries) begin
         mem_ready = ready_q.pop_front();
         @(negedge clk);
         check_val(tag_q.pop_front(), got, exp_q.pop_front());
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] i,
                            input int fw, input int mw);
      op = o; funct = f; instr74 = i;
      build(o, f, i, fw, mw);
      play(1000);
   endtask

   initial begin
      logic [1:0] ro;
      logic [5:0] rf;
      logic [3:0] ri;
      int         pick;
      reset_n = 1'b0; mem_ready = 1'b0; op = 2'b00; funct = 6'd0; instr74 = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check_val("in_reset", got, 22'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("RST", got, 22'd0);
      @(posedge clk); #1;

      run_instr(2'b00, 6'b001000, 4'b0000, 0, 0);   // ADD register
      run_instr(2'b01, 6'b000001, 4'b0000, 0, 2);   // LDR post-index, two MRD waits
      run_instr(2'b00, 6'b001001, 4'b1001, 0, 0);   // UMULL
      run_instr(2'b10, 6'b110000, 4'b0000, 0, 0);   // BL
      run_instr(2'b11, 6'b000000, 4'b0000, 1, 0);   // illegal op
      run_instr(2'b00, 6'b010010, 4'b0001, 0, 0);   // BX

      // STR abandoned by reset while waiting in MWR
      op = 2'b01; funct = 6'b011010; instr74 = 4'b0000;
      build(op, funct, instr74, 0, 3);
      play(3);
      mem_ready = 1'b0;
      @(negedge clk);
      check_val("MWR_wait", got, exp_q[0]);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("abort_req", {20'd0, mem_req, mem_w}, 22'd0);
      check_val("abort_all", got, 22'd0);
      exp_q.delete(); ready_q.delete(); tag_q.delete();
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_val("RST_again", got, 22'd0);
      @(posedge clk); #1;

      for (int n = 0; n < 200; n++) begin
         pick = $urandom_range(0, 9);
         ro = 2'($urandom_range(0, 3));
         rf = 6'($urandom_range(0, 63));
         ri = 4'($urandom_range(0, 15));
         if (pick <= 2) ro = 2'b00;
         else if (pick == 3) begin ro = 2'b00; rf = {2'b00, rf[3:0]}; ri = 4'b1001; end
         else if (pick == 4) begin ro = 2'b00; rf = 6'b010010; ri = ($urandom_range(0, 3) != 0) ? 4'b0001 : ri; end
         else if (pick <= 6) ro = 2'b01;
         else if (pick <= 8) ro = 2'b10;
         else ro = 2'b11;
         run_instr(ro, rf, ri, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
